// File: rtl/wb_queue.sv
// Writeback queue for the register-file write port.
// Two producers (A has priority over B) feed a circular buffer. The buffer
// drains one entry per cycle onto wa/wd/wpc and offers a bypass lookup so
// readers can see queued values before they reach the register file.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic [AW-1:0]              a_addr,
    input  logic [DW-1:0]              a_data,
    input  logic [DW-1:0]              a_pc,
    output logic                       a_ready,
    input  logic                       b_valid,
    input  logic [AW-1:0]              b_addr,
    input  logic [DW-1:0]              b_data,
    input  logic [DW-1:0]              b_pc,
    output logic                       b_ready,
    output logic [AW-1:0]              wa,
    output logic [DW-1:0]              wd,
    output logic [DW-1:0]              wpc,
    input  logic [AW-1:0]              q_addr,
    output logic                       q_hit,
    output logic [DW-1:0]              q_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_r [DEPTH];
    logic [DW-1:0] data_r [DEPTH];
    logic [DW-1:0] pc_r   [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          pop_s;
    logic [CW:0]   free_s;
    logic          a_en_s;
    logic          b_en_s;
    logic [PW-1:0] b_slot_s;
    logic          unused_s;

    // Only bits [4:0] select an architectural register; upper bits are ignored.
    assign unused_s = ^q_addr[AW-1:5];

    assign count = count_r;

    // Pop credit, free-slot accounting, ready handshakes and enqueue slots.
    always_comb begin
        pop_s    = (count_r != {CW{1'b0}});
        free_s   = (CW+1)'(DEPTH) - {1'b0, count_r} + {{CW{1'b0}}, pop_s};
        a_ready  = a_valid && (free_s >= (CW+1)'(1));
        if (a_valid) begin
            b_ready = b_valid && (free_s >= (CW+1)'(2));
        end else begin
            b_ready = b_valid && (free_s >= (CW+1)'(1));
        end
        // Writes to $0 are accepted but never stored.
        a_en_s   = a_ready && (a_addr[4:0] != 5'd0);
        b_en_s   = b_ready && (b_addr[4:0] != 5'd0);
        if (a_en_s) begin
            b_slot_s = tail_r + PW'(1);
        end else begin
            b_slot_s = tail_r;
        end
    end

    // Head entry drives the register-file write port; zeros when empty.
    always_comb begin
        if (pop_s) begin
            wa  = addr_r[head_r];
            wd  = data_r[head_r];
            wpc = pc_r[head_r];
        end else begin
            wa  = {AW{1'b0}};
            wd  = {DW{1'b0}};
            wpc = {DW{1'b0}};
        end
    end

    // Bypass lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        q_hit  = 1'b0;
        q_data = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_r) && (q_addr[4:0] != 5'd0) &&
                (addr_r[head_r + PW'(i)][4:0] == q_addr[4:0])) begin
                q_hit  = 1'b1;
                q_data = data_r[head_r + PW'(i)];
            end else begin
                q_hit  = q_hit;
                q_data = q_data;
            end
        end
    end

    // Queue storage, pointers and occupancy; one pop per cycle when non-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {AW{1'b0}};
                data_r[i] <= {DW{1'b0}};
                pc_r[i]   <= {DW{1'b0}};
            end
        end else begin
            if (a_en_s) begin
                addr_r[tail_r] <= a_addr;
                data_r[tail_r] <= a_data;
                pc_r[tail_r]   <= a_pc;
            end
            if (b_en_s) begin
                addr_r[b_slot_s] <= b_addr;
                data_r[b_slot_s] <= b_data;
                pc_r[b_slot_s]   <= b_pc;
            end
            head_r  <= head_r + PW'(pop_s);
            tail_r  <= tail_r + PW'(a_en_s) + PW'(b_en_s);
            count_r <= count_r - CW'(pop_s) + CW'(a_en_s) + CW'(b_en_s);
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed stimulus pushes expected writes,
// a negedge monitor pops and compares whatever the DUT drains.
module tb_wb_queue;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [5:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        a_ready;
    logic        b_valid;
    logic [5:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        b_ready;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic [5:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;
    logic [2:0]  count;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } wr_t;

    wr_t sb[$];
    int  total;
    int  fails;

    wb_queue #(.DEPTH(4), .AW(6), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_pc(a_pc), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_pc(b_pc), .b_ready(b_ready),
        .wa(wa), .wd(wd), .wpc(wpc),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every drained write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wa != 6'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {26'd0, wa}, 32'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("drain_addr", {26'd0, wa}, {26'd0, e.a});
                    chk("drain_data", wd, e.d);
                    chk("drain_pc", wpc, e.p);
                end
            end else begin
                chk("idle_wd", wd, 32'd0);
                chk("idle_wpc", wpc, 32'd0);
            end
        end
    end

    // One cycle of stimulus: present requests, check readiness, let the edge take them.
    task automatic step(input logic av, input logic [5:0] aa, input logic [31:0] ad, input logic [31:0] ap,
                        input logic bv, input logic [5:0] ba, input logic [31:0] bd, input logic [31:0] bp,
                        input logic ear, input logic ebr);
        a_valid = av; a_addr = aa; a_data = ad; a_pc = ap;
        b_valid = bv; b_addr = ba; b_data = bd; b_pc = bp;
        @(negedge clk);
        chk("a_ready", {31'd0, a_ready}, {31'd0, ear});
        chk("b_ready", {31'd0, b_ready}, {31'd0, ebr});
        if (ear && aa[4:0] != 5'd0) sb.push_back('{aa, ad, ap});
        if (ebr && ba[4:0] != 5'd0) sb.push_back('{ba, bd, bp});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; total = 0; fails = 0;
        a_valid = 1'b0; a_addr = 6'd0; a_data = 32'd0; a_pc = 32'd0;
        b_valid = 1'b0; b_addr = 6'd0; b_data = 32'd0; b_pc = 32'd0;
        q_addr = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        chk("rst_wa", {26'd0, wa}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_wpc", wpc, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_qhit", {31'd0, q_hit}, 32'd0);
        idle();

        // Single A write, visible for one cycle
        step(1'b1, 6'd5, 32'h1234, 32'h3000, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("single_wa", {26'd0, wa}, 32'd5);
        chk("single_count", {29'd0, count}, 32'd1);
        idle();
        chk("single_after_wa", {26'd0, wa}, 32'd0);
        chk("single_after_count", {29'd0, count}, 32'd0);

        // Simultaneous A/B to the same register; bypass returns the younger (B)
        step(1'b1, 6'd3, 32'hA, 32'h100, 1'b1, 6'd3, 32'hB, 32'h104, 1'b1, 1'b1);
        q_addr = 6'd3;
        #1;
        chk("dual_count", {29'd0, count}, 32'd2);
        chk("dual_qhit", {31'd0, q_hit}, 32'd1);
        chk("dual_qdata", q_data, 32'hB);
        idle();
        idle();
        q_addr = 6'd0;

        // Backpressure: queue grows by one per cycle until only one slot is free
        step(1'b1, 6'd1, 32'h11, 32'h200, 1'b1, 6'd2, 32'h22, 32'h204, 1'b1, 1'b1);
        step(1'b1, 6'd4, 32'h44, 32'h208, 1'b1, 6'd6, 32'h66, 32'h20C, 1'b1, 1'b1);
        step(1'b1, 6'd8, 32'h88, 32'h210, 1'b1, 6'd9, 32'h99, 32'h214, 1'b1, 1'b1);
        chk("bp_full_count", {29'd0, count}, 32'd4);
        step(1'b1, 6'd10, 32'hAA, 32'h218, 1'b1, 6'd11, 32'hBB, 32'h21C, 1'b1, 1'b0);
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd11, 32'hBB, 32'h21C, 1'b0, 1'b1);
        chk("bp_hold_count", {29'd0, count}, 32'd4);
        repeat (4) idle();
        chk("bp_drained_count", {29'd0, count}, 32'd0);

        // $0 filtering, including an upper-bit alias of $0
        step(1'b1, 6'd0, 32'hFF, 32'h300, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("r0_count", {29'd0, count}, 32'd0);
        step(1'b1, 6'h20, 32'hFF, 32'h304, 1'b1, 6'd12, 32'hC, 32'h308, 1'b1, 1'b1);
        chk("r0_alias_count", {29'd0, count}, 32'd1);
        q_addr = 6'd0;
        #1 chk("r0_qhit", {31'd0, q_hit}, 32'd0);
        q_addr = 6'h2C;
        #1 chk("alias_qhit", {31'd0, q_hit}, 32'd1);
        chk("alias_qdata", q_data, 32'hC);
        idle();
        q_addr = 6'd0;

        // Reset mid-operation discards queued entries immediately
        step(1'b1, 6'd13, 32'hD, 32'h400, 1'b1, 6'd14, 32'hE, 32'h404, 1'b1, 1'b1);
        step(1'b1, 6'd15, 32'hF, 32'h408, 1'b1, 6'd16, 32'h10, 32'h40C, 1'b1, 1'b1);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        q_addr = 6'd14;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_wa", {26'd0, wa}, 32'd0);
        chk("mid_rst_wd", wd, 32'd0);
        chk("mid_rst_qhit", {31'd0, q_hit}, 32'd0);
        chk("mid_rst_qdata", q_data, 32'd0);
        sb.delete();
        q_addr = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 6'd7, 32'h77, 32'h500, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("post_rst_wa", {26'd0, wa}, 32'd7);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        idle();
        chk("post_rst_drained", {29'd0, count}, 32'd0);

        // Bounded wait for the scoreboard to empty
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
